// File: rtl/bmem_pkg.sv
// Shared widths, FSM state encoding and beat helpers for the burst
// memory responder.
package bmem_pkg;

    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = 4;
    localparam int LINE_WIDTH = BEAT_WIDTH * BEATS;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT
    } state_e;

    function automatic logic [BEAT_WIDTH-1:0] beat_sel(
        input logic [LINE_WIDTH-1:0] line,
        input logic [1:0]            idx
    );
        return line[idx*BEAT_WIDTH +: BEAT_WIDTH];
    endfunction

endpackage

// File: rtl/bmem_if.sv
// Burst memory bus: requester drives address/commands/write data,
// responder returns read beats and the response strobe.
interface bmem_if;
    import bmem_pkg::*;

    logic [31:0]           bmem_address;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_resp;

    modport master (
        output bmem_address,
        output bmem_read,
        output bmem_write,
        output bmem_wdata,
        input  bmem_rdata,
        input  bmem_resp
    );

    modport slave (
        input  bmem_address,
        input  bmem_read,
        input  bmem_write,
        input  bmem_wdata,
        output bmem_rdata,
        output bmem_resp
    );

endinterface

// File: rtl/bmem_line_array.sv
// Line storage: synchronous full-line write, combinational read.
// Contents are deliberately not reset.
module bmem_line_array
    import bmem_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [LINE_WIDTH-1:0] wline_i,
    input  logic [IDX_W-1:0]      ridx_i,
    output logic [LINE_WIDTH-1:0] rline_o
);

    logic [LINE_WIDTH-1:0] mem_q [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wline_i;
        end
    end

    assign rline_o = mem_q[ridx_i];

endmodule

// File: rtl/bmem_responder.sv
// Burst memory responder: 4-beat line reads and writes with a fixed
// response latency and a sticky protocol-violation flag.
module bmem_responder
    import bmem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 64
) (
    input  logic  clk,
    input  logic  rst,
    bmem_if.slave bus,
    output logic  error
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT_LOAD =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [1:0]            beat_q;
    logic                  resp_q;
    logic [BEAT_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3*BEAT_WIDTH-1:0] wbuf_q;

    logic                  rd;
    logic                  wr;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      ridx;
    logic [LINE_WIDTH-1:0] rline;
    logic [LINE_WIDTH-1:0] wline_d;
    logic                  line_we_d;
    logic                  unused_addr;

    assign rd          = bus.bmem_read;
    assign wr          = bus.bmem_write;
    assign req_idx     = bus.bmem_address[IDX_W+4:5];
    assign unused_addr = ^{bus.bmem_address[31:IDX_W+5],
                           bus.bmem_address[4:0]};

    // In IDLE the array is addressed straight from the bus so that a
    // LATENCY of 1 can present beat 0 on the accepting edge.
    assign ridx = (state_q == IDLE) ? req_idx : idx_q;

    // Beat 3 comes straight off the bus; beats 0..2 sit in the shifter.
    assign wline_d   = {bus.bmem_wdata, wbuf_q};
    assign line_we_d = (state_q == WR_BURST) && wr && (beat_q == 2'd3);

    bmem_line_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_W)
    ) u_lines (
        .clk     (clk),
        .we_i    (line_we_d),
        .widx_i  (idx_q),
        .wline_i (wline_d),
        .ridx_i  (ridx),
        .rline_o (rline)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            beat_q  <= 2'd0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wbuf_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd && wr) begin
                        err_q <= 1'b1;
                    end else if (rd) begin
                        idx_q  <= req_idx;
                        beat_q <= 2'd0;
                        if (LATENCY == 1) begin
                            state_q <= RD_BURST;
                            resp_q  <= 1'b1;
                            rdata_q <= beat_sel(rline, 2'd0);
                        end else begin
                            state_q <= RD_WAIT;
                            cnt_q   <= LAT_LOAD;
                        end
                    end else if (wr) begin
                        idx_q   <= req_idx;
                        wbuf_q  <= {bus.bmem_wdata,
                                    wbuf_q[3*BEAT_WIDTH-1:BEAT_WIDTH]};
                        beat_q  <= 2'd1;
                        state_q <= WR_BURST;
                    end
                end
                RD_WAIT: begin
                    if (rd || wr) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        state_q <= RD_BURST;
                        resp_q  <= 1'b1;
                        beat_q  <= 2'd0;
                        rdata_q <= beat_sel(rline, 2'd0);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_BURST: begin
                    if (rd || wr) begin
                        err_q <= 1'b1;
                    end
                    if (beat_q == 2'd3) begin
                        state_q <= IDLE;
                        resp_q  <= 1'b0;
                        rdata_q <= '0;
                    end else begin
                        beat_q  <= beat_q + 2'd1;
                        rdata_q <= beat_sel(rline, beat_q + 2'd1);
                    end
                end
                WR_BURST: begin
                    if (rd) begin
                        err_q <= 1'b1;
                    end
                    if (!wr) begin
                        // Short burst: drop the partial line.
                        err_q   <= 1'b1;
                        beat_q  <= 2'd0;
                        state_q <= IDLE;
                    end else if (beat_q == 2'd3) begin
                        state_q <= WR_WAIT;
                        if (LATENCY == 1) begin
                            resp_q <= 1'b1;
                        end else begin
                            cnt_q <= LAT_LOAD;
                        end
                    end else begin
                        wbuf_q <= {bus.bmem_wdata,
                                   wbuf_q[3*BEAT_WIDTH-1:BEAT_WIDTH]};
                        beat_q <= beat_q + 2'd1;
                    end
                end
                WR_WAIT: begin
                    if (rd || wr) begin
                        err_q <= 1'b1;
                    end
                    if (resp_q) begin
                        resp_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        resp_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bmem_resp  = resp_q;
    assign bus.bmem_rdata = rdata_q;
    assign error          = err_q;

endmodule
